// File: rtl/drain_pkg.sv
// Shared constants for word_drain_streamer: one-hot state codes, size defaults, counter width.
// Optional feature macro: WORD_DRAIN_CHECKSUM_EN (adds the CSUM state and a 5-bit state vector).
package drain_pkg;

  localparam int W_DEF     = 16;
  localparam int DEPTH_DEF = 16;
  localparam int AW_DEF    = 4;

`ifdef WORD_DRAIN_CHECKSUM_EN
  localparam int STATE_W = 5;
`else
  localparam int STATE_W = 4;
`endif

  typedef logic [STATE_W-1:0] state_t;

  localparam state_t S_IDLE   = STATE_W'(1);
  localparam state_t S_LOAD   = STATE_W'(2);
  localparam state_t S_STREAM = STATE_W'(4);
  localparam state_t S_FIN    = STATE_W'(8);
`ifdef WORD_DRAIN_CHECKSUM_EN
  localparam state_t S_CSUM   = STATE_W'(16);
`endif

  // Width of a counter that indexes 0..depth-1; never narrower than one bit.
  function automatic int cnt_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/drain_out_slice.sv
// Stream output register: m_data load/hold, m_valid set/clear, m_last qualified by m_valid.
module drain_out_slice #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] din,
  input  logic         set_valid,
  input  logic         clr_valid,
  input  logic         last_cond,
  output logic [W-1:0] m_data,
  output logic         m_valid,
  output logic         m_last
);

  // NOTE: state is written with <= so every flop samples pre-edge values; = here would create order-dependent races.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      m_data  <= '0;
      m_valid <= 1'b0;
    end else begin
      if (load) m_data <= din;
      if (clr_valid)      m_valid <= 1'b0;
      else if (set_valid) m_valid <= 1'b1;
    end
  end

  assign m_last = m_valid & last_cond;

endmodule

// File: rtl/word_drain_streamer.sv
// Drains the packed-word RAM onto a valid/ready stream on each IDLE-time rising edge of fsm_done.
// Optional feature macro: WORD_DRAIN_CHECKSUM_EN appends a modulo-2^W sum beat to every run.
module word_drain_streamer
  import drain_pkg::*;
#(
  parameter int W     = W_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int AW    = AW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          fsm_done,
  output logic [AW-1:0] rd_add,
  input  logic [W-1:0]  rd_data,
  output logic [W-1:0]  m_data,
  output logic          m_valid,
  input  logic          m_ready,
  output logic          m_last,
  output logic          busy,
  output logic          drain_done
);

  localparam int             CW       = cnt_width(DEPTH);
  localparam logic [CW-1:0]  LAST_CNT = CW'(DEPTH - 1);

  state_t        state, state_nxt;
  logic          done_q;
  logic [CW-1:0] cnt;
  logic          start, hs, at_last;

  logic          out_load, set_valid, clr_valid, last_cond;
  logic [W-1:0]  out_din;
  logic          addr_clr, addr_inc, cnt_clr, cnt_inc;

`ifdef WORD_DRAIN_CHECKSUM_EN
  logic [W-1:0]  sum;
  logic          sum_clr, sum_add;
`endif

  assign start   = fsm_done & ~done_q;
  assign hs      = m_valid & m_ready;
  assign at_last = (cnt == LAST_CNT);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = S_IDLE;
    case (state)
      S_IDLE:   state_nxt = start ? S_LOAD : S_IDLE;
      S_LOAD:   state_nxt = S_STREAM;
`ifdef WORD_DRAIN_CHECKSUM_EN
      S_STREAM: state_nxt = (hs && at_last) ? S_CSUM : S_STREAM;
      S_CSUM:   state_nxt = hs ? S_FIN : S_CSUM;
`else
      S_STREAM: state_nxt = (hs && at_last) ? S_FIN : S_STREAM;
`endif
      S_FIN:    state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // NOTE: every signal driven here gets a default first, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    out_load  = 1'b0;
    out_din   = rd_data;
    set_valid = 1'b0;
    clr_valid = 1'b0;
    addr_clr  = 1'b0;
    addr_inc  = 1'b0;
    cnt_clr   = 1'b0;
    cnt_inc   = 1'b0;
`ifdef WORD_DRAIN_CHECKSUM_EN
    sum_clr   = 1'b0;
    sum_add   = 1'b0;
    last_cond = (state == S_CSUM);
`else
    last_cond = at_last;
`endif
    case (state)
      S_IDLE: begin
        addr_clr = 1'b1;
        cnt_clr  = 1'b1;
      end
      S_LOAD: begin
        out_load  = 1'b1;
        addr_inc  = 1'b1;
        set_valid = 1'b1;
`ifdef WORD_DRAIN_CHECKSUM_EN
        sum_clr   = 1'b1;
`endif
      end
      S_STREAM: begin
        if (hs) begin
`ifdef WORD_DRAIN_CHECKSUM_EN
          sum_add = 1'b1;
          if (at_last) begin
            // The final data word is folded in on the fly so the sum beat follows with no bubble.
            out_load = 1'b1;
            out_din  = sum + m_data;
          end else begin
            out_load = 1'b1;
            addr_inc = 1'b1;
            cnt_inc  = 1'b1;
          end
`else
          if (at_last) begin
            clr_valid = 1'b1;
          end else begin
            out_load = 1'b1;
            addr_inc = 1'b1;
            cnt_inc  = 1'b1;
          end
`endif
        end
      end
`ifdef WORD_DRAIN_CHECKSUM_EN
      S_CSUM: begin
        if (hs) clr_valid = 1'b1;
      end
`endif
      S_FIN: ;
      default: clr_valid = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      done_q <= 1'b0;
      rd_add <= '0;
      cnt    <= '0;
    end else begin
      done_q <= fsm_done;
      if (addr_clr)      rd_add <= '0;
      else if (addr_inc) rd_add <= rd_add + 1'b1;
      if (cnt_clr)       cnt <= '0;
      else if (cnt_inc)  cnt <= cnt + 1'b1;
    end
  end

`ifdef WORD_DRAIN_CHECKSUM_EN
  always_ff @(posedge clk) begin
    if (!rst_n)       sum <= '0;
    else if (sum_clr) sum <= '0;
    else if (sum_add) sum <= sum + m_data;
  end
`endif

  drain_out_slice #(.W(W)) u_out (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (out_load),
    .din       (out_din),
    .set_valid (set_valid),
    .clr_valid (clr_valid),
    .last_cond (last_cond),
    .m_data    (m_data),
    .m_valid   (m_valid),
    .m_last    (m_last)
  );

  assign busy       = (state != S_IDLE);
  assign drain_done = (state == S_FIN);

endmodule

// File: tb/tb_word_drain_streamer.sv
// Self-checking bench for word_drain_streamer: per-cycle comparison against a queue-based run model.
// Honours WORD_DRAIN_CHECKSUM_EN (expects the extra sum beat when defined).
module tb_word_drain_streamer;

  localparam int W     = 16;
  localparam int DEPTH = 16;
  localparam int AW    = 4;
`ifdef WORD_DRAIN_CHECKSUM_EN
  localparam int BEATS = DEPTH + 1;
`else
  localparam int BEATS = DEPTH;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          fsm_done = 1'b0;
  logic          m_ready = 1'b1;
  logic [AW-1:0] rd_add;
  logic [W-1:0]  rd_data;
  logic [W-1:0]  m_data;
  logic          m_valid, m_last, busy, drain_done;

  logic [W-1:0]  mem [DEPTH];
  assign rd_data = mem[rd_add];

  always #5 clk = ~clk;

  word_drain_streamer #(.W(W), .DEPTH(DEPTH), .AW(AW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .fsm_done   (fsm_done),
    .rd_add     (rd_add),
    .rd_data    (rd_data),
    .m_data     (m_data),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_last     (m_last),
    .busy       (busy),
    .drain_done (drain_done)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct { logic [W-1:0] d; bit last; } beat_t;
  typedef enum { PH_IDLE, PH_PRIME, PH_BEATS, PH_DONE } phase_t;

  beat_t  q[$];
  phase_t ph = PH_IDLE;
  bit     prev_done = 1'b0;
  bit     just_reset = 1'b0;
  int     run_beats = 0, last_cnt = 0, runs_done = 0;
  logic [W-1:0] first_data = '0, final_data = '0;
  bit     beat16_last = 1'b0;

  task automatic fill_queue();
    logic [W-1:0] s;
    s = '0;
    q.delete();
    for (int i = 0; i < DEPTH; i++) begin
      beat_t b;
      b.d = mem[i];
      s   = s + mem[i];
`ifdef WORD_DRAIN_CHECKSUM_EN
      b.last = 1'b0;
`else
      b.last = (i == DEPTH - 1);
`endif
      q.push_back(b);
    end
`ifdef WORD_DRAIN_CHECKSUM_EN
    begin
      beat_t c;
      c.d = s; c.last = 1'b1;
      q.push_back(c);
    end
`endif
  endtask

  initial begin
    @(posedge clk);
    forever begin
      @(negedge clk);
      check("busy", busy, ph != PH_IDLE);
      check("m_valid", m_valid, ph == PH_BEATS);
      check("drain_done", drain_done, ph == PH_DONE);
      if (ph == PH_BEATS) begin
        check("m_data", m_data, q[0].d);
        check("m_last", m_last, q[0].last);
      end else begin
        check("m_last_idle", m_last, 0);
      end
      if (ph == PH_PRIME) check("rd_add_load", rd_add, 0);
      if (just_reset) begin
        check("reset_m_data", m_data, 0);
        check("reset_rd_add", rd_add, 0);
        just_reset = 1'b0;
      end

      if (!rst_n) begin
        ph = PH_IDLE;
        q.delete();
        prev_done  = 1'b0;
        just_reset = 1'b1;
      end else begin
        bit st;
        st = fsm_done & ~prev_done;
        prev_done = fsm_done;
        case (ph)
          PH_IDLE: if (st) begin
            fill_queue();
            run_beats = 0; last_cnt = 0; beat16_last = 1'b0;
            ph = PH_PRIME;
          end
          PH_PRIME: ph = PH_BEATS;
          PH_BEATS: if (m_ready) begin
            if (run_beats == 0) first_data = m_data;
            final_data = m_data;
            run_beats++;
            if (m_last) last_cnt++;
            if (run_beats == DEPTH) beat16_last = m_last;
            void'(q.pop_front());
            if (q.size() == 0) ph = PH_DONE;
          end
          PH_DONE: begin
            runs_done++;
            ph = PH_IDLE;
          end
          default: ph = PH_IDLE;
        endcase
      end
    end
  end

  // ---------------- stimulus ----------------
  int ready_mode = 0;
  int cyc = 0;

  initial begin
    forever begin
      @(posedge clk); #1;
      cyc++;
      case (ready_mode)
        0: m_ready = 1'b1;
        1: m_ready = (cyc % 3 == 0);
        default: m_ready = $urandom_range(0, 1) == 1;
      endcase
    end
  end

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic pulse();
    fsm_done = 1'b1;
    step(1);
    fsm_done = 1'b0;
  endtask

  task automatic wait_done(input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (drain_done) begin seen = 1'b1; break; end
    end
    check({name, "_timeout"}, seen, 1);
    step(2);
  endtask

  task automatic load_pattern();
    for (int i = 0; i < DEPTH; i++) mem[i] = 16'hA500 + 16'(i);
  endtask

  task automatic load_random();
    for (int i = 0; i < DEPTH; i++) mem[i] = 16'($urandom);
  endtask

  initial begin
    int base;
    bit reached;
    load_pattern();
    step(3);
    rst_n = 1'b1;
    step(2);

    // Full-throughput run with latency probe.
    ready_mode = 0;
    fsm_done = 1'b1;
    @(posedge clk); #1;
    fsm_done = 1'b0;
    @(posedge clk); #1;
    check("latency_valid", m_valid, 1);
    check("latency_data", m_data, 16'hA500);
    wait_done("run1");
    check("run1_beats", run_beats, BEATS);
    check("run1_first", first_data, 16'hA500);
    check("run1_last_count", last_cnt, 1);
`ifndef WORD_DRAIN_CHECKSUM_EN
    check("run1_final", final_data, 16'hA50F);
`endif

    // Back-pressure pattern 1,0,0 repeating.
    ready_mode = 1;
    pulse();
    wait_done("run2");
    check("run2_beats", run_beats, BEATS);
    check("run2_first", first_data, 16'hA500);

    // Reset after the fifth beat, then restart.
    ready_mode = 2;
    pulse();
    reached = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (run_beats >= 5) begin reached = 1'b1; break; end
    end
    check("reach_5_beats", reached, 1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    step(1);
    rst_n = 1'b1;
    step(2);
    pulse();
    wait_done("run_after_reset");
    check("restart_first", first_data, 16'hA500);
    check("restart_beats", run_beats, BEATS);

    // fsm_done held high across the run, then a mid-run re-pulse.
    load_random();
    base = runs_done;
    fsm_done = 1'b1;
    wait_done("held");
    step(10);
    fsm_done = 1'b0;
    step(2);
    fsm_done = 1'b1;
    step(5);
    fsm_done = 1'b0;
    step(2);
    fsm_done = 1'b1;
    step(2);
    fsm_done = 1'b0;
    wait_done("repulse");
    step(6);
    check("runs_per_edge", runs_done - base, 2);

    // Randomized runs.
    for (int r = 0; r < 4; r++) begin
      load_random();
      pulse();
      wait_done("random_run");
      check("random_beats", run_beats, BEATS);
    end

`ifdef WORD_DRAIN_CHECKSUM_EN
    for (int i = 0; i < DEPTH; i++) mem[i] = 16'hFFFF;
    ready_mode = 0;
    pulse();
    wait_done("csum_run");
    check("csum_value", final_data, 16'hFFF0);
    check("csum_beat16_last", beat16_last, 0);
    check("csum_beats", run_beats, 17);
`endif

    step(3);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/word_drain_streamer.md
Name: word_drain_streamer

Overview:
Downstream stage of the byte-pair packing FSM. It watches that FSM's `done` flag and, on its rising edge, sweeps the 16x16 packed-word RAM read port (`rd_add`/`data_out`, asynchronous read) from address 0 to DEPTH-1. It emits every word, in address order, on a valid/ready stream with a last marker. It runs at full throughput (one word per cycle while `m_ready` is high) and honours back-pressure.

Parameters:
W, 16, word width; matches the packed-word RAM width.
DEPTH, 16, number of words drained per run; equals packed-RAM depth.
AW, 4, read-address width; must equal clog2(DEPTH).

Ports:
clk  input  1  system clock; all logic on posedge.
rst_n  input  1  reset, synchronous, active-low.
fsm_done  input  1  `done` level from the packing FSM.
rd_add  output  AW  packed-RAM read address (registered).
rd_data  input  W  packed-RAM `data_out`; combinational function of `rd_add`.
m_data  output  W  stream word.
m_valid  output  1  stream word valid.
m_ready  input  1  downstream accepts the word when high together with `m_valid`.
m_last  output  1  high with the final beat of a run.
busy  output  1  high from LOAD entry until return to IDLE.
drain_done  output  1  one-cycle pulse after the final beat handshakes.

Behaviour:
- Reset (`rst_n` low at posedge) puts the block in IDLE and clears all outputs, registered next edge:
  - `rd_add` = 0, `m_data` = 0, `m_valid` = 0, `m_last` = 0, `busy` = 0, `drain_done` = 0.
  - The word counter `cnt` and the edge register `done_q` = 0.
  - Reset mid-run aborts the run; no partial resume.
- Trigger:
  - `done_q` <= `fsm_done` every cycle.
  - `start` = `fsm_done` & ~`done_q`.
  - `start` is ignored outside IDLE.
- State machine, one-hot 4-bit: IDLE=0001, LOAD=0010, STREAM=0100, FIN=1000.
  - IDLE: if `start` -> LOAD; `rd_add` <= 0; `cnt` <= 0.
  - LOAD: `m_data` <= `rd_data` (word 0); `rd_add` <= `rd_add`+1; `m_valid` <= 1 -> STREAM.
  - STREAM, on handshake (`m_valid` & `m_ready`):
    - If `cnt` == DEPTH-1: `m_valid` <= 0 -> FIN.
    - Else: `m_data` <= `rd_data`; `rd_add` <= `rd_add`+1; `cnt` <= `cnt`+1; `m_valid` stays 1.
  - STREAM, no handshake: `m_data`, `rd_add` and `cnt` hold; `m_valid` stays 1.
  - FIN: `drain_done` = 1 for this cycle only -> IDLE.
  - Illegal encodings -> IDLE.
- Latency: `fsm_done` sampled high at edge N (with `done_q` = 0) -> LOAD at N -> `m_valid` high after edge N+1.
- Throughput: with `m_ready` held high, DEPTH beats in DEPTH consecutive cycles.
- Stream rules:
  - `m_data` is stable while `m_valid` & ~`m_ready`.
  - `m_valid` never drops without a handshake.
  - `m_last` = `m_valid` & (`cnt` == DEPTH-1).
- Wrap-around: `rd_add` wraps modulo DEPTH after the last fetch. This is harmless; it is reset to 0 at the next start.
- `fsm_done` falling, or rising again, mid-run has no effect; only an IDLE-time rising edge starts a run.
- `busy` = state != IDLE.

Optional Feature:
Macro WORD_DRAIN_CHECKSUM_EN.
- Defined:
  - A W-bit modulo-2^W sum of all words is accumulated on each data handshake and cleared at LOAD.
  - After the data word at `cnt` == DEPTH-1 handshakes, one extra beat carrying the sum is sent.
  - `m_last` moves to that checksum beat; FIN follows its handshake.
  - Adds state CSUM=0001_0000 (5-bit one-hot).
- Undefined: behaviour exactly as above; no accumulator, DEPTH beats per run.

Decomposition:
- Shared package `drain_pkg`:
  - One-hot state localparams (IDLE/LOAD/STREAM/FIN/CSUM).
  - W/DEPTH/AW defaults.
  - The `cnt` width function.
- One natural sub-module, `drain_out_slice`: the `m_data`/`m_valid`/`m_last` output register with load/hold/clear controls, driven by the FSM.

Test Plan:
- RAM word i = 16'hA500+i; pulse `fsm_done`; `m_ready`=1 -> 16 consecutive beats A500..A50F, `m_last` only on A50F, `drain_done` one cycle after it, `busy` low next cycle.
- Same data; `m_ready` toggles 1,0,0,1,... -> identical ordered sequence; `m_data` stable in every stalled cycle; no drops or duplicates.
- Assert `rst_n`=0 for 1 cycle after the 5th beat -> all outputs 0 at the next edge; new `fsm_done` rising edge restarts from A500.
- `fsm_done` held high across two runs, and re-pulsed mid-run -> exactly one run per IDLE-time rising edge; the mid-run pulse is ignored.
- Latency check: `fsm_done` 0->1 before edge N -> `m_valid`=1 after edge N+1, `m_data`=A500.
- WORD_DRAIN_CHECKSUM_EN defined, words all 16'hFFFF -> 17th beat = 16'hFFF0 with `m_last`; 16th beat has `m_last`=0.
